// File: rtl/mvu_pkg.sv
// Shared MVU constants and the per-entry quantizer configuration type.
package mvu_pkg;

    localparam int N        = 64;   // lanes per MVU vector
    localparam int BSCALERP = 27;   // scaler/pooler output lane width
    localparam int BQMSBIDX = 5;    // width of the quantizer msb index
    localparam int QBWOUTBD = 5;    // width of the quantizer output precision field
    localparam int BDBANKW  = N;    // data bank write word width

    // Configuration captured alongside each buffered vector.
    typedef struct packed {
        logic [BQMSBIDX-1:0] msbidx;
        logic [QBWOUTBD-1:0] bwout;
    } quant_cfg_t;

endpackage

// File: rtl/mvu_quantser_lane.sv
// One lane of the quantizer: selects bit (msbidx - k) of the lane,
// returning 0 when that index falls below bit 0.
module mvu_quantser_lane #(
    parameter int BWIN = 27,
    parameter int BMSB = 5,
    parameter int BBW  = 5
) (
    input  logic [BWIN-1:0] lane,
    input  logic [BMSB-1:0] msbidx,
    input  logic [BBW-1:0]  k,
    output logic            q
);
    import mvu_pkg::*;

    // One extra bit so the compare and subtraction never wrap.
    localparam int CW = ((BMSB > BBW) ? BMSB : BBW) + 1;

    logic [CW-1:0]   m_ext;
    logic [CW-1:0]   k_ext;
    logic [CW-1:0]   idx;
    logic [BWIN-1:0] shifted;

    // Shift the wanted bit down to position 0; indices past the MSB shift to 0.
    always_comb begin
        m_ext   = CW'(msbidx);
        k_ext   = CW'(k);
        idx     = m_ext - k_ext;
        shifted = lane >> idx;
        q       = (k_ext <= m_ext) ? shifted[0] : 1'b0;
    end

endmodule

// File: rtl/mvu_quantser.sv
// MVU output quantizer/serializer: buffers up to two vectors (active +
// pending) and emits a bwout+1 bit window of each lane, MSB first, one
// registered bit-plane per cycle.
//
// Handshake: a vector transfers on the rising edge where din_valid && din_ready.
// din_ready depends only on registered state (pending slot empty), never on
// din_valid. Asserting din_valid while din_ready is low drops the vector and
// sets the sticky ovf_err. The output side has no backpressure.
module mvu_quantser #(
    parameter int N    = mvu_pkg::N,
    parameter int BWIN = mvu_pkg::BSCALERP,
    parameter int BMSB = mvu_pkg::BQMSBIDX,
    parameter int BBW  = mvu_pkg::QBWOUTBD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*BWIN-1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [BMSB-1:0] msbidx,
    input  logic [BBW-1:0]  bwout,
    output logic [N-1:0]    dout,
    output logic            dout_valid,
    output logic            dout_last,
    output logic            busy,
    output logic            ovf_err,
    input  logic            clr_err,
    output logic            fsm_state
);
    import mvu_pkg::*;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [QBWOUTBD-1:0] k_q, k_d;
    logic [N*BWIN-1:0]   act_data_q, pend_data_q;
    quant_cfg_t          act_cfg_q, pend_cfg_q, din_cfg;
    logic                pend_full_q;
    logic                xfer;
    logic                last;
    logic                load_din;
    logic                load_pend;
    logic                fill_pend;
    logic [N-1:0]        plane;

    assign din_ready = !pend_full_q;
    assign xfer      = din_valid && din_ready;
    assign last      = (state_q == ST_SHIFT) && (k_q == act_cfg_q.bwout);
    assign busy      = (state_q == ST_SHIFT) || pend_full_q;
    assign fsm_state = state_q;

    // Clamp the incoming configuration to the lane width before it is stored.
    always_comb begin
        din_cfg        = '0;
        din_cfg.msbidx = (int'(msbidx) >= BWIN) ? BQMSBIDX'(BWIN - 1) : BQMSBIDX'(msbidx);
        din_cfg.bwout  = (int'(bwout) >= BWIN)  ? QBWOUTBD'(BWIN - 1) : QBWOUTBD'(bwout);
    end

    // Next-state logic: on the last plane, chain straight into the next vector.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        load_din  = 1'b0;
        load_pend = 1'b0;
        fill_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d  = ST_SHIFT;
                    k_d      = '0;
                    load_din = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (k_q == act_cfg_q.bwout) begin
                    k_d = '0;
                    if (pend_full_q) begin
                        load_pend = 1'b1;
                    end else if (xfer) begin
                        load_din = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    k_d       = k_q + QBWOUTBD'(1);
                    fill_pend = xfer;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Active / pending vector buffers with their stored configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data_q  <= '0;
            act_cfg_q   <= '0;
            pend_data_q <= '0;
            pend_cfg_q  <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (load_din) begin
                act_data_q <= din;
                act_cfg_q  <= din_cfg;
            end else if (load_pend) begin
                act_data_q <= pend_data_q;
                act_cfg_q  <= pend_cfg_q;
            end
            if (fill_pend) begin
                pend_data_q <= din;
                pend_cfg_q  <= din_cfg;
                pend_full_q <= 1'b1;
            end else if (load_pend) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            mvu_quantser_lane #(
                .BWIN (BWIN),
                .BMSB (BQMSBIDX),
                .BBW  (QBWOUTBD)
            ) u_lane (
                .lane   (act_data_q[gi*BWIN +: BWIN]),
                .msbidx (act_cfg_q.msbidx),
                .k      (k_q),
                .q      (plane[gi])
            );
        end
    endgenerate

    // Register the current bit-plane; dout is zero whenever it is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= (state_q == ST_SHIFT);
            dout       <= (state_q == ST_SHIFT) ? plane : '0;
            dout_last  <= last;
        end
    end

    // Sticky overflow flag; a new overflow outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (din_valid && !din_ready) begin
            ovf_err <= 1'b1;
        end else if (clr_err) begin
            ovf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvu_quantser.sv
// Directed + randomized bench for mvu_quantser.
module tb_mvu_quantser;
  import mvu_pkg::*;

  localparam int BWIN = BSCALERP;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N*BWIN-1:0]   din = '0;
  logic                din_valid = 1'b0;
  logic                din_ready;
  logic [BQMSBIDX-1:0] msbidx = '0;
  logic [QBWOUTBD-1:0] bwout = '0;
  logic [N-1:0]        dout;
  logic                dout_valid;
  logic                dout_last;
  logic                busy;
  logic                ovf_err;
  logic                clr_err = 1'b0;
  logic                fsm_state;

  logic [N-1:0] exp_q[$];
  logic         last_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  mvu_quantser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .msbidx     (msbidx),
    .bwout      (bwout),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .busy       (busy),
    .ovf_err    (ovf_err),
    .clr_err    (clr_err),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // model: bits msbidx down to msbidx-bwout (clamped), zero below bit 0
  task automatic push_model(input logic [N*BWIN-1:0] d, input int m, input int b);
    int mc;
    int bc;
    logic [N-1:0] p;
    logic [BWIN-1:0] ln;
    mc = (m >= BWIN) ? BWIN - 1 : m;
    bc = (b >= BWIN) ? BWIN - 1 : b;
    for (int k = 0; k <= bc; k++) begin
      for (int i = 0; i < N; i++) begin
        ln = d[i*BWIN +: BWIN];
        p[i] = (mc - k >= 0) ? ln[mc-k] : 1'b0;
      end
      exp_q.push_back(p);
      last_q.push_back(k == bc);
    end
  endtask

  // driver: waits (bounded) for din_ready, presents one vector for one edge,
  // leaves din_valid high so back-to-back calls stream without gaps
  task automatic send(input logic [N*BWIN-1:0] d, input int m, input int b);
    int cnt;
    cnt = 0;
    if (!din_ready) begin
      din_valid = 1'b0;
      while (!din_ready && cnt < 200) begin
        tick();
        cnt++;
      end
      if (!din_ready) check("ready_timeout", 64'd0, 64'd1);
    end
    din       = d;
    msbidx    = BQMSBIDX'(m);
    bwout     = QBWOUTBD'(b);
    din_valid = 1'b1;
    push_model(d, m, b);
    tick();
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    din_valid = 1'b0;
    while ((busy || dout_valid || exp_q.size() != 0) && cnt < 500) begin
      tick();
      cnt++;
    end
    if (cnt >= 500) check("drain_timeout", 64'd0, 64'd1);
  endtask

  // scoreboard: every valid plane must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plane", 64'd1, 64'd0);
      end else begin
        check("plane", dout, exp_q.pop_front());
        check("plane_last", 64'(dout_last), 64'(last_q.pop_front()));
      end
    end
  end

  initial begin
    logic [N*BWIN-1:0] v;
    logic [N*BWIN-1:0] v2;
    logic [7:0]        bits8;
    logic [7:0]        last8;
    logic [7:0]        rdy8;
    logic [3:0]        bits4;
    int                cnt;

    // reset state
    tick();
    tick();
    check("rst_dout", dout, 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_dout_last", 64'(dout_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    check("rst_ready", 64'(din_ready), 64'd1);
    check("rst_state", 64'(fsm_state), 64'd0);
    rst_n = 1'b1;

    // basic serialization, transfer in the first cycle after release
    v = '0;
    v[BWIN-1:0] = 27'h5A5A5A;
    bits8 = 8'b0101_1010;
    send(v, 7, 7);
    din_valid = 1'b0;
    check("lat_valid", 64'(dout_valid), 64'd0);
    check("lat_state", 64'(fsm_state), 64'd1);
    check("lat_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("basic_bit", dout, {56'd0, 7'd0, bits8[7-c]});
      check("basic_last", 64'(dout_last), 64'(c == 7));
      check("basic_valid", 64'(dout_valid), 64'd1);
    end
    tick();
    check("basic_end_valid", 64'(dout_valid), 64'd0);
    check("basic_end_busy", 64'(busy), 64'd0);
    wait_idle();

    // back-to-back, bwout=3
    v = '0;
    v2 = '0;
    for (int i = 0; i < N; i++) begin
      v[i*BWIN +: BWIN]  = BWIN'(i * 32'h3);
      v2[i*BWIN +: BWIN] = BWIN'(32'hF - i);
    end
    last8 = 8'b1000_1000;
    rdy8  = 8'b1111_1000;
    send(v, 3, 3);
    send(v2, 3, 3);
    din_valid = 1'b0;
    cnt = 0;
    for (int j = 1; j <= 8; j++) begin
      if (j > 1) tick();
      if (dout_valid) cnt++;
      check("b2b_last", 64'(dout_last), 64'(last8[j-1]));
      check("b2b_ready", 64'(din_ready), 64'(rdy8[j-1]));
    end
    tick();
    check("b2b_valid_cycles", 64'(cnt), 64'd8);
    check("b2b_end_valid", 64'(dout_valid), 64'd0);
    wait_idle();

    // zero padding below bit 0
    v = '1;
    send(v, 2, 5);
    din_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("pad_plane", dout, (c < 3) ? {64{1'b1}} : 64'd0);
      check("pad_last", 64'(dout_last), 64'(c == 5));
    end
    wait_idle();

    // msbidx clamp: 31 behaves as 26
    v = '0;
    v[BWIN-1:0] = 27'h5000000;
    bits4 = 4'b1010;
    send(v, 31, 3);
    din_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("clamp_msb_bit", 64'(dout[0]), 64'(bits4[3-c]));
    end
    wait_idle();

    // bwout clamp: 31 behaves as 26 -> 27 planes
    for (int i = 0; i < N; i++) v[i*BWIN +: BWIN] = BWIN'($urandom());
    send(v, 26, 31);
    din_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dout_valid) cnt++;
    end
    check("clamp_bw_planes", 64'(cnt), 64'd27);
    wait_idle();

    // overflow with both entries full
    v[BWIN-1:0] = 27'h00000FF;
    send(v, 7, 7);
    send(v, 7, 7);
    check("ovf_ready_low", 64'(din_ready), 64'd0);
    din = '1;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("ovf_set", 64'(ovf_err), 64'd1);
    check("ovf_busy", 64'(busy), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf_clear", 64'(ovf_err), 64'd0);
    check("ovf_ready_low2", 64'(din_ready), 64'd0);
    din_valid = 1'b1;
    clr_err = 1'b1;
    tick();
    din_valid = 1'b0;
    check("ovf_set_wins", 64'(ovf_err), 64'd1);
    tick();
    clr_err = 1'b0;
    check("ovf_clear2", 64'(ovf_err), 64'd0);
    wait_idle();
    check("ovf_idle_flag", 64'(ovf_err), 64'd0);

    // asynchronous reset at k=3 of an 8-bit vector
    v = '0;
    v[BWIN-1:0] = 27'h5A5A5A;
    send(v, 7, 7);
    din_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_valid_pre", 64'(dout_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_q.delete();
    #1;
    check("arst_dout", dout, 64'd0);
    check("arst_valid", 64'(dout_valid), 64'd0);
    check("arst_last", 64'(dout_last), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(din_ready), 64'd1);
    check("arst_state", 64'(fsm_state), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    v[BWIN-1:0] = 27'h00000C3;
    send(v, 7, 7);
    din_valid = 1'b0;
    check("post_rst_lat", 64'(dout_valid), 64'd0);
    tick();
    check("post_rst_first", 64'(dout[0]), 64'd1);
    wait_idle();

    // randomized vectors against the model
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < N; i++) v[i*BWIN +: BWIN] = BWIN'($urandom());
      send(v, $urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        tick();
      end
    end
    wait_idle();
    check("rand_ovf", 64'(ovf_err), 64'd0);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
